call_stack: RTL
===============

// Module: call_stack
// PURPOSE
//  Parametrised return-address stack for the next SAP-2 core; replaces the single-level
//  subroutine counter and its JK select flip-flop. Allows JMS nesting up to DEPTH levels.
//  JMS pushes the return address; BRB pops it and drives it onto the bus for the PC load.
//  Sits beside the program counter on the address half of the bus, driven by control unit.
// PARAMETERS
//  AW     8  address width (return-address bits, = PC width)
//  DEPTH  4  number of stack entries, >= 2
//  CW     3  count width, = $clog2(DEPTH+1)
// PORTS
//  clk      in   1      system clock, rising-edge active
//  clr      in   1      asynchronous reset, active-high
//  push     in   1      write din as new top (JMS)
//  pop      in   1      remove top (BRB)
//  din      in   AW     return address to push (PC value)
//  es       in   1      drive current top onto bus
//  bus      out  AW     tri-state: top when es=1 and empty=0, else 'z
//  top      out  AW     current top entry; combinational from registers
//  count    out  CW     number of valid entries, 0..DEPTH
//  empty    out  1      count==0
//  full     out  1      count==DEPTH
//  err      out  1      sticky overflow/underflow flag
//  err_clr  in   1      synchronous clear of err
// BEHAVIOUR
//  - Reset (clr=1, any time, mid-operation included): sp=0, count=0, err=0, empty=1,
//    full=0, top=0, bus='z. Entry contents are not reset.
//  - All updates happen on the rising clk edge. top/count/flags reflect the edge one cycle later.
//    No other latency.
//  - push only, not full: mem[sp]<=din, sp<=sp+1 mod DEPTH, count+1.
//  - pop only, not empty: sp<=sp-1 mod DEPTH, count-1. The old top is visible on bus/top
//    during the pop cycle, so the control unit asserts es and pop in the same state.
//  - push & pop, count>0: top entry replaced by din; sp and count unchanged (tail-call).
//  - push & pop, count==0: the push is performed, the pop is ignored, err<=1.
//  - pop only, empty: no state change, err<=1 (underflow).
//  - push only, full: see CONFIGURATION.
//  - top = mem[sp-1 mod DEPTH] when count>0, else 0.
//  - err is sticky. err_clr clears it unless an error event occurs in the same cycle;
//    the error event wins.
//  - es with empty=1: bus stays 'z (no drive of stale data).
// CONFIGURATION
//  CALL_STACK_WRAP_EN defined:
//    - push when full overwrites the oldest entry: mem[sp]<=din, sp advances,
//      count stays DEPTH, err unchanged.
//    - After that, DEPTH pops return the newest DEPTH addresses.
//  CALL_STACK_WRAP_EN undefined:
//    - push when full is rejected: no change to mem/sp/count, err<=1 (overflow).
//  push&pop when full: the replace-top rule applies in both configurations.
// STRUCTURE
//  - Shared package sap2_pkg: AW_DEFAULT=8, DEPTH_DEFAULT=4, typedef addr_t [AW-1:0],
//    and the control-word bit indices for push/pop/es, reused by the hard-wired control unit.
//  - Sub-module stack_regfile: DEPTH x AW register array, one write port, one
//    asynchronous read port, no reset.
//  - call_stack keeps sp, count, err and the tri-state driver.
// TESTING
//  1 Reset: clr pulse mid-push -> count=0, empty=1, err=0, bus='z.
//  2 Nesting: push 8'h10, 8'h20, 8'h30; then pop x3 with es=1 -> bus 30,20,10;
//    then empty=1, err=0.
//  3 Full: DEPTH=4, push 1,2,3,4,5.
//    Without WRAP: count=4, err=1, pops give 4,3,2,1.
//    With WRAP: err=0, pops give 5,4,3,2.
//  4 Underflow: pop when empty -> count=0, err=1; err_clr -> err=0 next cycle;
//    err_clr together with a pop on empty -> err stays 1.
//  5 Push&pop: push 8'hA0, then push&pop with din=8'hB0 -> top=B0, count=1;
//    push&pop on empty with din=8'h55 -> top=55, count=1, err=1.
//  6 Bus: es=1 with count=2 -> bus=top; es=0 or empty -> bus='z (checked with a weak pull).

Source files
------------

// File: rtl/sap2_pkg.sv
// sap2_pkg: shared SAP-2 widths, address type, control-word bit positions and
// the call-stack operation decode used by the stack and the hard-wired control unit.
package sap2_pkg;
  localparam int AW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 4;
  typedef logic [AW_DEFAULT-1:0] addr_t;
  localparam int CTL_PUSH = 0;
  localparam int CTL_POP  = 1;
  localparam int CTL_ES   = 2;
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_FIRST,
    OP_OVF,
    OP_UNF
  } stack_op_t;
  function automatic stack_op_t decode_op(input logic push, input logic pop,
                                          input logic empty, input logic full);
    return (push && pop) ? (empty ? OP_FIRST : OP_REPL) :
           push          ? (full  ? OP_OVF   : OP_PUSH) :
           pop           ? (empty ? OP_UNF   : OP_POP)  : OP_IDLE;
  endfunction
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x AW return-address storage, one write port, one asynchronous
// read port; contents are deliberately not reset.
module stack_regfile #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [SW-1:0] i_waddr,
  input  logic [AW-1:0] i_wdata,
  input  logic [SW-1:0] i_raddr,
  output logic [AW-1:0] o_rdata
);
  logic [AW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/call_stack.sv
// call_stack: return-address stack for JMS/BRB nesting with a tri-state bus driver.
// Define CALL_STACK_WRAP_EN to make a push on a full stack overwrite the oldest entry.
module call_stack
  import sap2_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  input  logic          es,
  output tri   [AW-1:0] bus,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err,
  input  logic          err_clr
);
  localparam int SW = $clog2(DEPTH);
`ifdef CALL_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [SW-1:0] r_sp, w_sp_inc, w_sp_dec, w_sp_nxt, w_waddr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_err, w_err_evt, w_we;
  logic [AW-1:0] w_rdata;
  stack_op_t     w_op;
  assign empty    = r_count == '0;
  assign full     = r_count == CW'(DEPTH);
  assign w_op     = decode_op(push, pop, empty, full);
  assign w_sp_inc = (r_sp == SW'(DEPTH - 1)) ? '0 : r_sp + SW'(1);
  assign w_sp_dec = (r_sp == '0) ? SW'(DEPTH - 1) : r_sp - SW'(1);
  // replace-top rewrites the entry below sp; every other write lands at sp and advances it
  always_comb begin
    w_we        = (w_op inside {OP_PUSH, OP_REPL, OP_FIRST}) || (WRAP && w_op == OP_OVF);
    w_waddr     = (w_op == OP_REPL) ? w_sp_dec : r_sp;
    w_sp_nxt    = (w_we && w_op != OP_REPL) ? w_sp_inc : (w_op == OP_POP) ? w_sp_dec : r_sp;
    w_count_nxt = (w_op inside {OP_PUSH, OP_FIRST}) ? r_count + CW'(1) :
                  (w_op == OP_POP) ? r_count - CW'(1) : r_count;
    w_err_evt   = (w_op inside {OP_FIRST, OP_UNF}) || (!WRAP && w_op == OP_OVF);
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_sp    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sp    <= w_sp_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_evt | (r_err & ~err_clr);
    end
  stack_regfile #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_regfile (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(din),
    .i_raddr(w_sp_dec),
    .o_rdata(w_rdata)
  );
  assign count = r_count;
  assign err   = r_err;
  assign top   = empty ? '0 : w_rdata;
  assign bus   = (es && !empty) ? top : 'z;
endmodule
